csa_tree_pipe: RTL and testbench

Parametrised, pipelined multi-operand adder for the Sobel convolution datapath. It reduces NUM_IN operands of IN_W bits through registered levels of 3:2 carry-save compressors, then resolves the final sum/carry pair in a registered carry-propagate stage. It sits between the 3x3 window/weight stage and gradient magnitude logic. Throughput is one operand set per cycle, with a valid/ready handshake and whole-pipeline stall.

---
 rtl/csa_tree_pkg.sv | 35 +++
 rtl/csa_tree_pipe_if.sv | 26 ++
 rtl/csa_3_2.sv | 13 +
 rtl/csa_tree_pipe.sv | 109 ++++++++++
 tb/tb_csa_tree_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_tree_pkg.sv
// Shared helpers for the pipelined carry-save adder tree: width/level math
// and parameter legality checks used at elaboration time.
package csa_tree_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int csa_levels(input int num_in);
    if (num_in <= 3) return 1;
    else if (num_in == 4) return 2;
    else if (num_in <= 6) return 3;
    else return 4;
  endfunction

  function automatic int out_width(input int in_w, input int num_in);
    return in_w + clog2(num_in);
  endfunction

  // Rows present at the input of level lvl (0 = the extended operands)
  function automatic int rows_at(input int num_in, input int lvl);
    int r;
    r = num_in;
    for (int i = 0; i < lvl; i++) r = r - r / 3;
    return r;
  endfunction

  function automatic bit params_ok(input int in_w, input int num_in);
    return (in_w >= 4) && (in_w <= 16) && (num_in >= 3) && (num_in <= 9);
  endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Operand/result handshake bundle for csa_tree_pipe; the adder is the slave.
interface csa_tree_pipe_if
  import csa_tree_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int NUM_IN = 9
);
  localparam int OUT_W = out_width(IN_W, NUM_IN);

  logic [NUM_IN*IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [OUT_W-1:0]       out_sum;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_valid
  );
endinterface

// File: rtl/csa_3_2.sv
// Combinational 3:2 compressor; cy is the unshifted per-bit majority.
module csa_3_2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] cy
);
  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand adder: input register, CSA levels, carry-propagate add.
// Optional absolute-value output stage when CSA_TREE_ABS_EN is defined.
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int NUM_IN = 9,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_tree_pipe_if.slave  bus
);
  localparam int OUT_W  = out_width(IN_W, NUM_IN);
  localparam int LEVELS = csa_levels(NUM_IN);
`ifdef CSA_TREE_ABS_EN
  localparam int NST = LEVELS + 3;
`else
  localparam int NST = LEVELS + 2;
`endif

  if (!params_ok(IN_W, NUM_IN)) begin : g_bad_params
    $error("csa_tree_pipe: IN_W must be 4..16 and NUM_IN 3..9");
  end

  logic             advance;
  logic [NST-1:0]   vld_q;
  logic [OUT_W-1:0] ext   [NUM_IN];
  logic [OUT_W-1:0] stg_q [0:LEVELS][NUM_IN];
  logic [OUT_W-1:0] nxt   [1:LEVELS][NUM_IN];
  logic [OUT_W-1:0] sum_q;

  // One global enable: the whole pipe moves or the whole pipe holds
  assign advance      = !vld_q[NST-1] | bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_q[NST-1];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
    logic [IN_W-1:0] op;
    assign op     = bus.in_data[k*IN_W +: IN_W];
    assign ext[k] = {{(OUT_W-IN_W){SIGNED & op[IN_W-1]}}, op};
  end

  // Level l compresses groups of three rows from stage l-1; leftovers pass
  // through and the unused tail of the row array is tied to zero.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N = rows_at(NUM_IN, l - 1);
    localparam int G = N / 3;
    localparam int R = N % 3;

    for (genvar j = 0; j < G; j++) begin : g_grp
      logic [OUT_W-1:0] s;
      logic [OUT_W-1:0] cy;
      csa_3_2 #(.WIDTH(OUT_W)) u_csa (
        .a (stg_q[l-1][3*j]),
        .b (stg_q[l-1][3*j+1]),
        .c (stg_q[l-1][3*j+2]),
        .s (s),
        .cy(cy)
      );
      assign nxt[l][2*j]   = s;
      assign nxt[l][2*j+1] = cy << 1;
    end

    for (genvar j = 0; j < R; j++) begin : g_pass
      assign nxt[l][2*G+j] = stg_q[l-1][3*G+j];
    end

    for (genvar k = 2*G + R; k < NUM_IN; k++) begin : g_zero
      assign nxt[l][k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum_q <= '0;
      for (int l = 0; l <= LEVELS; l++)
        for (int k = 0; k < NUM_IN; k++)
          stg_q[l][k] <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[NST-2:0], bus.in_valid};
      for (int k = 0; k < NUM_IN; k++)
        stg_q[0][k] <= ext[k];
      for (int l = 1; l <= LEVELS; l++)
        for (int k = 0; k < NUM_IN; k++)
          stg_q[l][k] <= nxt[l][k];
      sum_q <= stg_q[LEVELS][0] + stg_q[LEVELS][1];
    end
  end

`ifdef CSA_TREE_ABS_EN
  logic [OUT_W-1:0] abs_q;

  // Magnitude of the signed sum; unsigned builds just register the sum again
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abs_q <= '0;
    end else if (advance) begin
      abs_q <= (SIGNED && sum_q[OUT_W-1]) ? (~sum_q + 1'b1) : sum_q;
    end
  end

  assign bus.out_sum = abs_q;
`else
  assign bus.out_sum = sum_q;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed-vector and streaming checks for csa_tree_pipe on three configurations:
// 9x8 unsigned, 9x8 signed, 4x8 signed.
module tb_csa_tree_pipe;

`ifdef CSA_TREE_ABS_EN
  localparam bit ABS  = 1'b1;
  localparam int XTRA = 1;
`else
  localparam bit ABS  = 1'b0;
  localparam int XTRA = 0;
`endif

  typedef struct {
    int          s;
    logic [71:0] d;
    logic [11:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [71:0] in_data;

  int          nvec = 0;
  int          nmis = 0;
  int          sel  = 0;
  logic        sv;
  logic        sr;
  logic [11:0] ss;

  always #5 clk = ~clk;

  csa_tree_pipe_if #(.IN_W(8), .NUM_IN(9)) if0 ();
  csa_tree_pipe_if #(.IN_W(8), .NUM_IN(9)) if1 ();
  csa_tree_pipe_if #(.IN_W(8), .NUM_IN(4)) if2 ();

  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.out_ready = out_ready;
  assign if2.in_data   = in_data[31:0];
  assign if2.in_valid  = in_valid;
  assign if2.out_ready = out_ready;

  csa_tree_pipe #(.IN_W(8), .NUM_IN(9), .SIGNED(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  csa_tree_pipe #(.IN_W(8), .NUM_IN(9), .SIGNED(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  csa_tree_pipe #(.IN_W(8), .NUM_IN(4), .SIGNED(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  always_comb begin
    sv = 1'b0;
    sr = 1'b0;
    ss = '0;
    case (sel)
      0: begin sv = if0.out_valid; sr = if0.in_ready; ss = if0.out_sum; end
      1: begin sv = if1.out_valid; sr = if1.in_ready; ss = if1.out_sum; end
      default: begin sv = if2.out_valid; sr = if2.in_ready; ss = {2'b00, if2.out_sum}; end
    endcase
  end

  function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic int lat_of(input int s);
    return ((s == 2) ? 3 : 5) + XTRA;
  endfunction

  // Plain integer reference sum for a given configuration
  function automatic logic [11:0] model(input int s, input logic [71:0] d);
    int          acc;
    int          n;
    logic [31:0] t;
    acc = 0;
    n = (s == 2) ? 4 : 9;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = d[8*k +: 8];
      acc += (s == 0) ? int'(b) : int'($signed(b));
    end
    if (s != 0 && ABS && acc < 0) acc = -acc;
    t = acc;
    return t[11:0] & ((s == 2) ? 12'h3FF : 12'hFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int s, input logic [71:0] d);
    sel = s;
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready_before_accept", {31'b0, sr}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp, input int lat);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (cyc < 30 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      got = sv;
    end
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_lat"}, cyc, lat);
      check({name, "_sum"}, {20'b0, ss}, {20'b0, exp});
    end
    repeat (8) @(posedge clk);
  endtask

  // Random stream with random bubbles and back-pressure, in-order scoreboard
  task automatic runStream(input int s, input int nsets, input int inPct, input int rdyPct);
    logic [11:0] expq[$];
    int          sent;
    int          recv;
    int          cyc;
    bit          fireIn;
    bit          fireOut;
    bit          prevStall;
    logic [11:0] prevSum;
    sel = s;
    sent = 0;
    recv = 0;
    cyc = 0;
    fireIn = 1'b0;
    prevStall = 1'b0;
    prevSum = '0;
    in_valid = 1'b0;
    while ((sent < nsets || recv < nsets) && cyc < nsets * 20 + 100) begin
      @(negedge clk);
      cyc++;
      if (fireIn) in_valid = 1'b0;
      if (!in_valid && sent < nsets && $urandom_range(99) < inPct) begin
        in_data[31:0]  = $urandom;
        in_data[63:32] = $urandom;
        in_data[71:64] = 8'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(99) < rdyPct);
      #1;
      check("in_ready_rule", {31'b0, sr}, {31'b0, (!sv | out_ready)});
      if (prevStall) check("stall_hold", {19'b0, sv, ss}, {20'b1, prevSum});
      fireIn  = in_valid & sr;
      fireOut = sv & out_ready;
      if (fireOut) begin
        if (expq.size() == 0) begin
          check("extra_output", 32'd1, 32'd0);
        end else begin
          check("stream_sum", {20'b0, ss}, {20'b0, expq[0]});
          void'(expq.pop_front());
        end
        recv++;
      end
      if (fireIn) begin
        expq.push_back(model(s, in_data));
        sent++;
      end
      prevStall = sv & !out_ready;
      prevSum = ss;
    end
    check("stream_complete", recv, nsets);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  vec_t tbl[11];

  initial begin
    bit sawValid;

    tbl[0]  = '{0, pk(255, 255, 255, 255, 255, 255, 255, 255, 255), 12'd2295, "u_all255"};
    tbl[1]  = '{0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0), 12'd0, "u_zero"};
    tbl[2]  = '{0, pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 12'd45, "u_ramp"};
    tbl[3]  = '{0, pk(255, 0, 255, 0, 255, 0, 255, 0, 255), 12'd1275, "u_alt"};
    tbl[4]  = '{1, pk(-1, 0, 1, -2, 0, 2, -1, 0, 1), 12'd0, "s_sobel"};
    tbl[5]  = '{1, pk(-128, -128, -128, -128, -128, -128, -128, -128, -128),
                ABS ? 12'd1152 : 12'd2944, "s_all_min"};
    tbl[6]  = '{1, pk(127, 127, 127, 127, 127, 127, 127, 127, 127), 12'd1143, "s_all_max"};
    tbl[7]  = '{1, pk(-1, -1, -1, -1, -1, -1, -1, -1, -1), ABS ? 12'd9 : 12'd4087, "s_all_m1"};
    tbl[8]  = '{2, pk(-128, -128, -128, -128, 0, 0, 0, 0, 0), 12'd512, "s4_all_min"};
    tbl[9]  = '{2, pk(127, 127, 127, 127, 0, 0, 0, 0, 0), 12'd508, "s4_all_max"};
    tbl[10] = '{2, pk(-1, 2, -3, 1, 0, 0, 0, 0, 0), ABS ? 12'd1 : 12'd1023, "s4_neg1"};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid0", {31'b0, if0.out_valid}, 32'd0);
    check("rst_sum0", {20'b0, if0.out_sum}, 32'd0);
    check("rst_ready0", {31'b0, if0.in_ready}, 32'd1);
    check("rst_valid1", {31'b0, if1.out_valid}, 32'd0);
    check("rst_valid2", {31'b0, if2.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'b0, if0.in_ready}, 32'd1);

    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].s, tbl[i].d);
      checkOutput(tbl[i].name, tbl[i].exp, lat_of(tbl[i].s));
    end

    $display("[TB] streaming");
    runStream(0, 20, 80, 50);
    runStream(1, 200, 70, 60);
    runStream(2, 200, 100, 100);

    $display("[TB] reset with full pipeline");
    sel = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(255, 255, 255, 255, 255, 255, 255, 255, 255);
    repeat (8) @(negedge clk);
    check("full_valid", {31'b0, if0.out_valid}, 32'd1);
    check("full_stalled", {31'b0, if0.in_ready}, 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'b0, if0.out_valid}, 32'd0);
    check("midrst_sum", {20'b0, if0.out_sum}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sawValid  = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (if0.out_valid || if1.out_valid || if2.out_valid) sawValid = 1'b1;
    end
    check("no_stale_output", {31'b0, sawValid}, 32'd0);
    applyStimulus(0, pk(1, 1, 1, 1, 1, 1, 1, 1, 1));
    checkOutput("post_rst", 12'd9, lat_of(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
